// File: rtl/vote_packet_processor.sv
`default_nettype none
// ==========================================================================
// vote_packet_processor: framed vote packet parser with XOR checksum,
// candidate range check, inter-byte timeout and valid/stall output hold.
// Revision: 1.0
// ==========================================================================
module vote_packet_processor #(
  parameter int         NUM_CANDIDATES  = 4,
  parameter int         CANDIDATE_WIDTH = (NUM_CANDIDATES > 1) ? $clog2(NUM_CANDIDATES) : 1,
  parameter int         VOTER_ID_BYTES  = 2,
  parameter logic [7:0] SYNC_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES  = 100_000
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        valid_in,
  input  logic [7:0]                  new_byte_in,
  input  logic                        stall_in,
  output logic [CANDIDATE_WIDTH-1:0]  vote_out,
  output logic [8*VOTER_ID_BYTES-1:0] voter_id_out,
  output logic                        valid_vote_out,
  output logic                        checksum_err_out,
  output logic                        range_err_out,
  output logic                        timeout_err_out,
  output logic                        dropped_out
);

  localparam int               ID_W       = 8 * VOTER_ID_BYTES;
  localparam int               TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]       ID_LAST    = 3'(VOTER_ID_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]       NUM_CAND_9 = 9'(NUM_CANDIDATES);

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    ID    = 3'd1,
    CAND  = 3'd2,
    CHECK = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        cand_q, cand_d;
  logic [7:0]        csum_q, csum_d;
  logic [2:0]        id_cnt_q, id_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              valid_q, valid_d;
  logic              chk_err_q, chk_err_d;
  logic              rng_err_q, rng_err_d;
  logic              tmo_err_q, tmo_err_d;
  logic              drop_q, drop_d;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    cand_d    = cand_q;
    csum_d    = csum_q;
    id_cnt_d  = id_cnt_q;
    tmo_d     = tmo_q;
    chk_err_d = 1'b0;
    rng_err_d = 1'b0;
    tmo_err_d = 1'b0;
    drop_d    = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (valid_in && (new_byte_in == SYNC_BYTE)) begin
          state_d  = ID;
          id_cnt_d = '0;
          csum_d   = '0;
          tmo_d    = '0;
        end
      end
      ID: begin
        if (valid_in) begin
          id_d       = id_q << 8;
          id_d[7:0]  = new_byte_in;
          csum_d     = csum_q ^ new_byte_in;
          id_cnt_d   = id_cnt_q + 3'd1;
          if (id_cnt_q == ID_LAST) state_d = CAND;
        end
      end
      CAND: begin
        if (valid_in) begin
          cand_d  = new_byte_in;
          csum_d  = csum_q ^ new_byte_in;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Checksum failure masks any range error on the same packet.
        if (valid_in) begin
          if (new_byte_in != csum_q) begin
            chk_err_d = 1'b1;
            state_d   = HUNT;
          end else if ({1'b0, cand_q} >= NUM_CAND_9) begin
            rng_err_d = 1'b1;
            state_d   = HUNT;
          end else begin
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        drop_d = valid_in;
        if (!stall_in) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase

    // A byte arriving on the terminal idle cycle wins over the timeout.
    if ((state_q == ID) || (state_q == CAND) || (state_q == CHECK)) begin
      if (valid_in) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_err_d = 1'b1;
        state_d   = HUNT;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= HUNT;
      id_q      <= '0;
      cand_q    <= '0;
      csum_q    <= '0;
      id_cnt_q  <= '0;
      tmo_q     <= '0;
      valid_q   <= 1'b0;
      chk_err_q <= 1'b0;
      rng_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      cand_q    <= cand_d;
      csum_q    <= csum_d;
      id_cnt_q  <= id_cnt_d;
      tmo_q     <= tmo_d;
      valid_q   <= valid_d;
      chk_err_q <= chk_err_d;
      rng_err_q <= rng_err_d;
      tmo_err_q <= tmo_err_d;
      drop_q    <= drop_d;
    end
  end

  assign vote_out         = cand_q[CANDIDATE_WIDTH-1:0];
  assign voter_id_out     = id_q;
  assign valid_vote_out   = valid_q;
  assign checksum_err_out = chk_err_q;
  assign range_err_out    = rng_err_q;
  assign timeout_err_out  = tmo_err_q;
  assign dropped_out      = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_packet_processor.sv
`default_nettype none
// ==========================================================================
// tb_vote_packet_processor: directed + random packets against a byte-list
// reference model. Revision: 1.0
// ==========================================================================
module tb_vote_packet_processor;

  localparam int NC   = 4;
  localparam int VB   = 2;
  localparam int TO   = 20;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  new_byte_in = 8'h00;
  logic        stall_in = 1'b0;
  logic [1:0]  vote_out;
  logic [15:0] voter_id_out;
  logic        valid_vote_out, checksum_err_out, range_err_out, timeout_err_out, dropped_out;

  logic        v1 = 1'b0;
  logic [7:0]  b1 = 8'h00;
  logic        s1 = 1'b0;
  logic [0:0]  vote1;
  logic [31:0] id1;
  logic        valid1, chk1, rng1, to1, drop1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit rnd_stall = 1'b0;

  always #5 clk = ~clk;

  vote_packet_processor #(
    .NUM_CANDIDATES(NC), .VOTER_ID_BYTES(VB), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .new_byte_in(new_byte_in),
    .stall_in(stall_in), .vote_out(vote_out), .voter_id_out(voter_id_out),
    .valid_vote_out(valid_vote_out), .checksum_err_out(checksum_err_out),
    .range_err_out(range_err_out), .timeout_err_out(timeout_err_out),
    .dropped_out(dropped_out)
  );

  vote_packet_processor #(
    .NUM_CANDIDATES(2), .VOTER_ID_BYTES(4), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)
  ) dut_wide (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(v1), .new_byte_in(b1),
    .stall_in(s1), .vote_out(vote1), .voter_id_out(id1),
    .valid_vote_out(valid1), .checksum_err_out(chk1),
    .range_err_out(rng1), .timeout_err_out(to1), .dropped_out(drop1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the bytes of a packet and judges it as a whole.
  bit          m_hold = 1'b0;
  bit          m_inpkt = 1'b0;
  logic [7:0]  m_q[$];
  int          m_idle = 0;
  bit          e_chk = 1'b0, e_rng = 1'b0, e_to = 1'b0, e_drop = 1'b0;
  logic [7:0]  e_vote = 8'h00;
  logic [15:0] e_id = 16'h0000;

  task automatic model_reset();
    m_hold = 1'b0; m_inpkt = 1'b0; m_q.delete(); m_idle = 0;
    e_chk = 1'b0; e_rng = 1'b0; e_to = 1'b0; e_drop = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0]  x;
    logic [15:0] id;
    e_chk = 1'b0; e_rng = 1'b0; e_to = 1'b0; e_drop = 1'b0;
    if (m_hold) begin
      if (valid_in) e_drop = 1'b1;
      if (!stall_in) m_hold = 1'b0;
    end else if (!m_inpkt) begin
      if (valid_in && new_byte_in == SYNC) begin
        m_inpkt = 1'b1; m_q.delete(); m_idle = 0;
      end
    end else if (valid_in) begin
      m_q.push_back(new_byte_in);
      m_idle = 0;
      if (m_q.size() == VB + 2) begin
        x = 8'h00; id = 16'h0000;
        for (int i = 0; i < VB + 1; i++) x ^= m_q[i];
        for (int i = 0; i < VB; i++) id = (id << 8) | 16'(m_q[i]);
        if (x != m_q[VB + 1]) e_chk = 1'b1;
        else if (int'(m_q[VB]) >= NC) e_rng = 1'b1;
        else begin
          m_hold = 1'b1; e_vote = m_q[VB]; e_id = id;
        end
        m_inpkt = 1'b0;
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        e_to = 1'b1; m_inpkt = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid_vote", valid_vote_out, m_hold);
      check("checksum_err", checksum_err_out, e_chk);
      check("range_err", range_err_out, e_rng);
      check("timeout_err", timeout_err_out, e_to);
      check("dropped", dropped_out, e_drop);
      if (m_hold) begin
        check("vote", vote_out, e_vote[1:0]);
        check("voter_id", voter_id_out, e_id);
      end
    end
  end

  task automatic step();
    if (rnd_stall) stall_in = ($urandom_range(0, 2) == 0);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    valid_in = 1'b1; new_byte_in = b;
    step();
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d);
    send(SYNC); send(a); send(b); send(c); send(d);
  endtask

  task automatic send1(input logic [7:0] b);
    v1 = 1'b1; b1 = b;
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic rand_packet();
    logic [7:0] x;
    logic [7:0] pkt[$];
    x = 8'h00;
    pkt.push_back(SYNC);
    for (int i = 0; i < VB; i++) begin
      pkt.push_back(8'($urandom));
      x ^= pkt[pkt.size() - 1];
    end
    pkt.push_back(8'($urandom_range(0, 5)));
    x ^= pkt[pkt.size() - 1];
    if ($urandom_range(0, 4) == 0) x ^= 8'h5A;
    pkt.push_back(x);
    foreach (pkt[i]) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 29) == 0) idle(TO + 1);
      send(pkt[i]);
    end
  endtask

  int hi_cnt;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_valid", valid_vote_out, 1'b0);
    check("reset_vote", vote_out, 2'd0);
    check("reset_id", voter_id_out, 16'h0000);
    check("reset_errs", {checksum_err_out, range_err_out, timeout_err_out, dropped_out}, 4'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(2);

    // Good packet, no stall: single-cycle valid.
    send_pkt(8'h01, 8'h02, 8'h03, 8'h00);
    check("good_valid", valid_vote_out, 1'b1);
    check("good_vote", vote_out, 2'd3);
    check("good_id", voter_id_out, 16'h0102);
    idle(1);
    check("good_pulse_end", valid_vote_out, 1'b0);

    // Stalled hold with one dropped byte, then the next packet.
    stall_in = 1'b1;
    send_pkt(8'h01, 8'h02, 8'h03, 8'h00);
    hi_cnt = int'(valid_vote_out);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin valid_in = 1'b1; new_byte_in = 8'h77; end
      @(negedge clk);
      valid_in = 1'b0;
      if (k == 4) check("hold_drop", dropped_out, 1'b1);
      check("hold_vote", vote_out, 2'd3);
      check("hold_id", voter_id_out, 16'h0102);
      hi_cnt += int'(valid_vote_out);
    end
    stall_in = 1'b0;
    idle(1);
    hi_cnt += int'(valid_vote_out);
    check("hold_cycles", hi_cnt, 11);
    send_pkt(8'h00, 8'h05, 8'h01, 8'h04);
    check("next_vote", vote_out, 2'd1);
    check("next_id", voter_id_out, 16'h0005);
    idle(1);

    // Checksum and range errors.
    send_pkt(8'h01, 8'h02, 8'h03, 8'h55);
    check("chk_err", checksum_err_out, 1'b1);
    check("chk_novalid", valid_vote_out, 1'b0);
    send_pkt(8'h00, 8'h00, 8'h07, 8'h07);
    check("rng_err", range_err_out, 1'b1);
    check("rng_chk_quiet", checksum_err_out, 1'b0);

    // Timeout after TO idle cycles, then a good packet.
    send(SYNC); send(8'h01);
    idle(TO - 1);
    check("to_not_yet", timeout_err_out, 1'b0);
    idle(1);
    check("to_pulse", timeout_err_out, 1'b1);
    send_pkt(8'h01, 8'h02, 8'h03, 8'h00);
    check("after_to_valid", valid_vote_out, 1'b1);
    idle(1);

    // Byte on the terminal cycle prevents the timeout.
    send(SYNC); send(8'h01);
    idle(TO - 1);
    send(8'h02);
    check("terminal_no_to", timeout_err_out, 1'b0);
    send(8'h03); send(8'h00);
    check("terminal_valid", valid_vote_out, 1'b1);
    check("terminal_vote", vote_out, 2'd3);
    idle(1);

    // Asynchronous reset mid-ID and during HOLD.
    send(SYNC); send(8'h01);
    #2 rst_n = 1'b0;
    #1 check("rst_id_outs", {valid_vote_out, checksum_err_out, range_err_out,
                             timeout_err_out, dropped_out}, 5'h0);
    @(negedge clk); rst_n = 1'b1;
    stall_in = 1'b1;
    send_pkt(8'h01, 8'h02, 8'h03, 8'h00);
    idle(2);
    check("pre_rst_hold", valid_vote_out, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("rst_hold_valid", valid_vote_out, 1'b0);
    check("rst_hold_vote", vote_out, 2'd0);
    check("rst_hold_id", voter_id_out, 16'h0000);
    @(negedge clk); rst_n = 1'b1; stall_in = 1'b0;
    send(8'h12); send(8'h34);
    check("garbage_ignored", valid_vote_out, 1'b0);
    send_pkt(8'h01, 8'h02, 8'h03, 8'h00);
    check("post_rst_vote", vote_out, 2'd3);
    check("post_rst_id", voter_id_out, 16'h0102);
    idle(1);

    // Wide instance: NUM_CANDIDATES=2, VOTER_ID_BYTES=4.
    send1(SYNC); send1(8'hDE); send1(8'hAD); send1(8'hBE); send1(8'hEF);
    send1(8'h01); send1(8'h23);
    check("wide_valid", valid1, 1'b1);
    check("wide_vote", vote1, 1'b1);
    check("wide_id", id1, 32'hDEADBEEF);
    @(negedge clk);
    send1(SYNC); send1(8'hDE); send1(8'hAD); send1(8'hBE); send1(8'hEF);
    send1(8'h02); send1(8'h20);
    check("wide_rng", rng1, 1'b1);
    check("wide_rng_novalid", valid1, 1'b0);

    // Randomized traffic with random stall and stray bytes.
    rnd_stall = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) send(8'($urandom));
      rand_packet();
      idle($urandom_range(0, 2));
    end
    rnd_stall = 1'b0;
    stall_in = 1'b0;
    idle(TO + 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
